// File: rtl/cpu_axi_bridge_pkg.sv
// cpu_axi_bridge shared types: AXI constants, FSM encodings, size helper.
// Used by the bridge top, write sub-module and interface users.
package cpu_axi_bridge_pkg;

  localparam int AXI_ID_INST = 0;
  localparam int AXI_ID_DATA = 1;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_R,
    R_DONE
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_B,
    W_DONE
  } w_state_t;

  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// AXI3 single-beat master bus between cpu_axi_bridge and the interconnect.
// Only the channels the bridge uses; burst fields are tied by the master.
interface cpu_axi_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [3:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic                rvalid;
  logic                rready;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [ID_W-1:0]     wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bvalid,
    input  bready
  );
endinterface

// File: rtl/cpu_axi_bridge_wr.sv
// Write side of cpu_axi_bridge: store latch, AW/W issue in either order,
// B wait and a one-cycle completion pulse.
module cpu_axi_bridge_wr
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [1:0]          size,
  input  logic [DATA_W/8-1:0] strb,
  input  logic [DATA_W-1:0]   data,
  output logic                idle,
  output logic                done,
  output logic [ADDR_W-1:0]   awaddr,
  output logic [2:0]          awsize,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic                bvalid,
  output logic                bready
);
  w_state_t state, state_nxt;
  logic aw_done, w_done;
  logic aw_fire, w_fire;

  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= W_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      W_IDLE: if (start) state_nxt = W_REQ;
      W_REQ: begin
        if ((aw_done | aw_fire) & (w_done | w_fire))
          state_nxt = W_B;
      end
      W_B:    if (bvalid) state_nxt = W_DONE;
      W_DONE: state_nxt = W_IDLE;
      default: state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    idle    = 1'b0;
    done    = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    unique case (state)
      W_IDLE: idle = 1'b1;
      W_REQ: begin
        awvalid = ~aw_done;
        wvalid  = ~w_done;
      end
      W_B:    bready = 1'b1;
      W_DONE: done = 1'b1;
      default: ;
    endcase
  end

  // AW and W retire independently; remember which one already fired
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else if (state != W_REQ) begin
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      awaddr <= '0;
      awsize <= '0;
      wdata  <= '0;
      wstrb  <= '0;
    end else if (start & idle) begin
      awaddr <= addr;
      awsize <= axi_size(size);
      wdata  <= data;
      wstrb  <= strb;
    end
  end

endmodule

// File: rtl/cpu_axi_bridge.sv
// Core inst/data SRAM-like channels to one AXI3 single-beat master.
// CPU_BRIDGE_RAW_ADDR_CMP_EN: word-address RAW compare instead of any-write block.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [1:0]          inst_size,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  cpu_axi_bridge_if.master    axi
);
  r_state_t rstate, rnext;
  logic data_busy, data_rd;
  logic rd_ok, rd_grant, raw_hit;
  logic w_idle, w_done, w_start;
  logic arvalid, rready, r_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [ID_W-1:0]   arid_q;
  logic [ADDR_W-1:0] araddr_q;
  logic [2:0]        arsize_q;
  logic [DATA_W-1:0] rdata_q;

  assign data_rd = data_req & ~data_wr & ~data_busy;
  assign rd_addr = data_rd ? data_addr : inst_addr;

`ifdef CPU_BRIDGE_RAW_ADDR_CMP_EN
  assign raw_hit = ~w_idle &
    (axi.awaddr[ADDR_W-1:2] == rd_addr[ADDR_W-1:2]);
`else
  assign raw_hit = ~w_idle;
`endif

  // data loads win the read port; inst only gets it when no load asks
  assign rd_ok        = (rstate == R_IDLE) & ~raw_hit;
  assign data_addr_ok = data_req & ~data_busy &
                        (data_wr ? w_idle : rd_ok);
  assign inst_addr_ok = inst_req & rd_ok & ~data_rd;
  assign rd_grant     = inst_addr_ok | (data_rd & rd_ok);
  assign w_start      = data_req & data_wr & data_addr_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rstate <= R_IDLE;
    else      rstate <= rnext;
  end

  always_comb begin
    rnext = rstate;
    unique case (rstate)
      R_IDLE: if (rd_grant) rnext = R_AR;
      R_AR:   if (axi.arready) rnext = R_R;
      R_R:    if (axi.rvalid) rnext = R_DONE;
      R_DONE: rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  always_comb begin
    arvalid = 1'b0;
    rready  = 1'b0;
    r_done  = 1'b0;
    unique case (rstate)
      R_AR:   arvalid = 1'b1;
      R_R:    rready = 1'b1;
      R_DONE: r_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arid_q   <= '0;
      araddr_q <= '0;
      arsize_q <= '0;
      rdata_q  <= '0;
    end else begin
      if (rd_grant) begin
        arid_q   <= data_rd ? ID_W'(AXI_ID_DATA) : ID_W'(AXI_ID_INST);
        araddr_q <= rd_addr;
        arsize_q <= axi_size(data_rd ? data_size : inst_size);
      end
      if ((rstate == R_R) & axi.rvalid) rdata_q <= axi.rdata;
    end
  end

  // one data-channel transaction at a time, load or store
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          data_busy <= 1'b0;
    else if (data_req & data_addr_ok)  data_busy <= 1'b1;
    else if (data_data_ok)             data_busy <= 1'b0;
  end

  assign inst_data_ok = r_done & (arid_q == ID_W'(AXI_ID_INST));
  assign data_data_ok = (r_done & (arid_q == ID_W'(AXI_ID_DATA))) | w_done;
  assign inst_rdata   = rdata_q;
  assign data_rdata   = rdata_q;

  assign axi.arid    = arid_q;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = 4'd0;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = AXI_BURST_INCR;
  assign axi.arvalid = arvalid;
  assign axi.rready  = rready;
  assign axi.awid    = ID_W'(AXI_ID_DATA);
  assign axi.awlen   = 4'd0;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wid     = ID_W'(AXI_ID_DATA);
  assign axi.wlast   = 1'b1;

  cpu_axi_bridge_wr #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr (
    .clk     (clk),
    .rst     (rst),
    .start   (w_start),
    .addr    (data_addr),
    .size    (data_size),
    .strb    (data_wstrb),
    .data    (data_wdata),
    .idle    (w_idle),
    .done    (w_done),
    .awaddr  (axi.awaddr),
    .awsize  (axi.awsize),
    .awvalid (axi.awvalid),
    .awready (axi.awready),
    .wdata   (axi.wdata),
    .wstrb   (axi.wstrb),
    .wvalid  (axi.wvalid),
    .wready  (axi.wready),
    .bvalid  (axi.bvalid),
    .bready  (axi.bready)
  );

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge with a wait-programmable AXI slave.
// Build with or without CPU_BRIDGE_RAW_ADDR_CMP_EN.
module tb_cpu_axi_bridge;
  logic        clk;
  logic        rst;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  cpu_axi_bridge_if axi ();

  cpu_axi_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .inst_req     (inst_req),
    .inst_size    (inst_size),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wstrb   (data_wstrb),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .axi          (axi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // slave knobs and state
  int ar_wait = 0, aw_wait = 0, w_wait = 0, r_wait = 0;
  bit r_rand = 0, b_hold = 0;
  int ar_cnt, aw_cnt, w_cnt, r_cnt, r_lat;
  bit r_pend, aw_seen, w_seen, b_pend;
  logic [31:0] r_addr, cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb, r_id;
  logic aw_fire, w_fire;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h3C08_0001 : ~a;
  endfunction

  assign aw_fire     = axi.awvalid && axi.awready;
  assign w_fire      = axi.wvalid && axi.wready;
  assign axi.arready = axi.arvalid && (ar_cnt >= ar_wait);
  assign axi.rvalid  = r_pend && (r_cnt >= r_lat);
  assign axi.rdata   = mem(r_addr);
  assign axi.rid     = r_id;
  assign axi.awready = axi.awvalid && (aw_cnt >= aw_wait);
  assign axi.wready  = axi.wvalid && (w_cnt >= w_wait);
  assign axi.bvalid  = b_pend && !b_hold;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ar_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; r_cnt <= 0; r_lat <= 0;
      r_pend <= 0; aw_seen <= 0; w_seen <= 0; b_pend <= 0;
      r_addr <= '0; r_id <= '0;
    end else begin
      ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.wvalid && !axi.wready) ? w_cnt + 1 : 0;
      if (axi.arvalid && axi.arready) begin
        r_pend <= 1; r_cnt <= 0; r_addr <= axi.araddr; r_id <= axi.arid;
        r_lat  <= r_rand ? int'($urandom_range(5, 0)) : r_wait;
      end else if (r_pend) begin
        if (axi.rvalid && axi.rready) r_pend <= 0;
        else r_cnt <= r_cnt + 1;
      end
      if (aw_fire) begin aw_seen <= 1; cap_awaddr <= axi.awaddr; end
      if (w_fire) begin
        w_seen <= 1; cap_wdata <= axi.wdata; cap_wstrb <= axi.wstrb;
      end
      if ((aw_seen || aw_fire) && (w_seen || w_fire) && !b_pend) begin
        b_pend <= 1; aw_seen <= 0; w_seen <= 0;
      end
      if (b_pend && axi.bvalid && axi.bready) b_pend <= 0;
    end
  end

  int inst_dok_n = 0, data_dok_n = 0;
  always @(posedge clk) begin
    #3;
    if (inst_data_ok === 1'b1) inst_dok_n++;
    if (data_data_ok === 1'b1) data_dok_n++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic wait_dok(input bit dch, input int lim, input string tag);
    int n = 0;
    while (((dch ? data_data_ok : inst_data_ok) !== 1'b1) && n < lim) begin
      step();
      n++;
    end
    checks++;
    assert ((dch ? data_data_ok : inst_data_ok) === 1'b1) else begin
      errors++;
      $error("FAIL %s data_ok observed=0 expected=1 after %0d cycles", tag, n);
    end
  endtask

  initial begin
    int bad, n0, d0, n;
    rst = 0;
    inst_req = 0; inst_size = 2'd2; inst_addr = '0;
    data_req = 0; data_wr = 0; data_size = 2'd2;
    data_addr = '0; data_wstrb = '0; data_wdata = '0;
    step(); step();
    #1;
    chkb("rst_arvalid", axi.arvalid, 1'b0);
    chkb("rst_awvalid", axi.awvalid, 1'b0);
    chkb("rst_wvalid", axi.wvalid, 1'b0);
    chkb("rst_rready", axi.rready, 1'b0);
    chkb("rst_bready", axi.bready, 1'b0);
    chkb("rst_inst_dok", inst_data_ok, 1'b0);
    chkb("rst_data_dok", data_data_ok, 1'b0);
    chk("rst_rdata", inst_rdata, 32'h0);
    step(); rst = 1; step();

    // 1: zero-wait inst fetch, data_ok three cycles after addr_ok
    inst_req = 1; inst_addr = 32'hBFC0_0000; #1;
    chkb("t1_addr_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 0;
    chkb("t1_arvalid", axi.arvalid, 1'b1);
    chk("t1_araddr", axi.araddr, 32'hBFC0_0000);
    chk("t1_arid", 32'(axi.arid), 32'd0);
    chk("t1_arsize", 32'(axi.arsize), 32'd2);
    chk("t1_arburst", 32'(axi.arburst), 32'd1);
    step();
    chkb("t1_dok_c2", inst_data_ok, 1'b0);
    step();
    chkb("t1_dok_c3", inst_data_ok, 1'b1);
    chk("t1_rdata", inst_rdata, 32'h3C08_0001);
    step();
    chkb("t1_dok_c4", inst_data_ok, 1'b0);

    // 2: data load beats a same-cycle fetch
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_wr = 0; data_addr = 32'h8000_1000; #1;
    chkb("t2_data_ok", data_addr_ok, 1'b1);
    chkb("t2_inst_blk", inst_addr_ok, 1'b0);
    step(); data_req = 0;
    chk("t2_arid_d", 32'(axi.arid), 32'd1);
    chk("t2_araddr_d", axi.araddr, 32'h8000_1000);
    wait_dok(1, 10, "t2_load");
    chk("t2_ldata", data_rdata, 32'h7FFF_EFFF);
    chkb("t2_inst_wait", inst_addr_ok, 1'b0);
    step(); #1;
    chkb("t2_inst_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 0;
    chk("t2_arid_i", 32'(axi.arid), 32'd0);
    wait_dok(0, 10, "t2_fetch");
    chk("t2_idata", inst_rdata, 32'h403F_FFFB);
    step();

    // 3: W handshakes two cycles before AW
    aw_wait = 2; w_wait = 0;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0010;
    data_wstrb = 4'b0011; data_wdata = 32'h1234_ABCD; #1;
    chkb("t3_addr_ok", data_addr_ok, 1'b1);
    step(); data_req = 0; data_wr = 0;
    chkb("t3_aw_c1", axi.awvalid, 1'b1);
    chkb("t3_w_c1", axi.wvalid, 1'b1);
    chk("t3_awsize", 32'(axi.awsize), 32'd2);
    chk("t3_awid", 32'(axi.awid), 32'd1);
    chkb("t3_wlast", axi.wlast, 1'b1);
    step();
    chkb("t3_w_drop", axi.wvalid, 1'b0);
    chkb("t3_aw_hold", axi.awvalid, 1'b1);
    d0 = data_dok_n;
    wait_dok(1, 10, "t3_store");
    chk("t3_awaddr", cap_awaddr, 32'h8000_0010);
    chk("t3_wdata", cap_wdata, 32'h1234_ABCD);
    chk("t3_wstrb", 32'(cap_wstrb), 32'd3);
    step(); step();
    chk("t3_one_dok", data_dok_n - d0, 32'd1);
    aw_wait = 0;

    // 4: read after store to the same word waits for the store
    b_hold = 1;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0020;
    data_wstrb = 4'hF; data_wdata = 32'hCAFE_F00D; #1;
    chkb("t4_st_ok", data_addr_ok, 1'b1);
    step(); data_req = 0; data_wr = 0;
    step();
    chkb("t4_in_wb", axi.bready, 1'b1);
    inst_req = 1; inst_addr = 32'h8000_0020;
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      if (inst_addr_ok || axi.arvalid) bad++;
      step();
    end
    chk("t4_raw_block", bad, 32'd0);
    inst_addr = 32'h8000_0040; #1;
`ifdef CPU_BRIDGE_RAW_ADDR_CMP_EN
    chkb("t4_nohit_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 0;
    chkb("t4_ar_in_wb", axi.arvalid && axi.bready, 1'b1);
    wait_dok(0, 10, "t4_nohit");
    chk("t4_nohit_data", inst_rdata, 32'h7FFF_FFBF);
`else
    chkb("t4_any_block", inst_addr_ok, 1'b0);
    inst_req = 0;
`endif
    b_hold = 0;
    wait_dok(1, 10, "t4_store");
    chkb("t4_no_ar", axi.arvalid, 1'b0);
    step();
    inst_req = 1; inst_addr = 32'h8000_0020; #1;
    chkb("t4_raw_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 0;
    wait_dok(0, 10, "t4_raw_rd");
    chk("t4_raw_data", inst_rdata, 32'h7FFF_FFDF);
    step();

    // 5: reset with AR and AW/W in flight
    ar_wait = 10; aw_wait = 10; w_wait = 10;
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    data_req = 1; data_wr = 1; data_addr = 32'h8000_0100; #1;
    chkb("t5_both_ok", inst_addr_ok && data_addr_ok, 1'b1);
    step(); inst_req = 0; data_req = 0; data_wr = 0;
    chkb("t5_pre_ar", axi.arvalid, 1'b1);
    chkb("t5_pre_aw", axi.awvalid && axi.wvalid, 1'b1);
    rst = 0; #1;
    chkb("t5_ar_drop", axi.arvalid, 1'b0);
    chkb("t5_aw_drop", axi.awvalid, 1'b0);
    chkb("t5_w_drop", axi.wvalid, 1'b0);
    ar_wait = 0; aw_wait = 0; w_wait = 0;
    step(); rst = 1; step();
    inst_req = 1; inst_addr = 32'hBFC0_0000; #1;
    chkb("t5_post_ok", inst_addr_ok, 1'b1);
    step(); inst_req = 0;
    wait_dok(0, 10, "t5_post");
    chk("t5_post_data", inst_rdata, 32'h3C08_0001);
    step();

    // 6: 100 fetches with random R latency
    r_rand = 1;
    n0 = inst_dok_n; d0 = data_dok_n; bad = 0;
    for (int i = 0; i < 100; i++) begin
      inst_req = 1; inst_addr = 32'h9000_0000 + 32'(4 * i); #1;
      n = 0;
      while (inst_addr_ok !== 1'b1 && n < 10) begin step(); #1; n++; end
      if (inst_addr_ok !== 1'b1) bad++;
      step(); inst_req = 0;
      wait_dok(0, 20, "t6_fetch");
      chk("t6_data", inst_rdata, ~(32'h9000_0000 + 32'(4 * i)));
      step();
      if (inst_data_ok !== 1'b0) bad++;
    end
    step();
    chk("t6_dok_count", inst_dok_n - n0, 32'd100);
    chk("t6_no_data_dok", data_dok_n - d0, 32'd0);
    chk("t6_pulse_addr", bad, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
